// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous block-RAM port between instruction fetch
// and load/store, hiding the fixed read latency behind a req/ack handshake.
module mem_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int MEM_AW       = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RWAIT = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_data_q, last_data_d;
  logic              gnt_data_q, gnt_data_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              i_ack_q, i_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              pick_data_s;
  logic              addr_unused_s;

  // Byte-lane bits and bits above the memory window are deliberately not decoded.
  assign addr_unused_s = ^{i_addr, d_addr};

  // Next-state, grant and output computation.
  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    cnt_d       = cnt_q;
    i_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pick_data_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          // On a tie the requester that did not win last time gets the port.
          pick_data_s = d_req && (!i_req || !last_data_q);
          last_data_d = pick_data_s;
          gnt_data_d  = pick_data_s;
          if (pick_data_s && (d_addr[1:0] != 2'b00)) begin
            state_d = S_ACK;
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            mem_en_d   = 1'b1;
            mem_we_d   = pick_data_s && d_we;
            mem_addr_d = pick_data_s ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
            if (pick_data_s && d_we) begin
              mem_wdata_d = d_wdata;
            end else begin
              mem_wdata_d = mem_wdata_q;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = {MEM_AW{1'b0}};
        if (mem_we_q) begin
          state_d = S_ACK;
          d_ack_d = 1'b1;
        end else begin
          state_d = S_RWAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_RWAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          if (gnt_data_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_data_q <= 1'b1;
      gnt_data_q  <= 1'b0;
      cnt_q       <= 4'd0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= {DATA_W{1'b0}};
      d_ack_q     <= 1'b0;
      d_rdata_q   <= {DATA_W{1'b0}};
      d_err_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {MEM_AW{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      cnt_q       <= cnt_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
